// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

    function automatic int level_width(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: one synchronous write port, one combinational read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter  int BITS = 32,
    parameter  int SIZE = 16,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [BITS-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [BITS-1:0] rdata_o
);

    logic [BITS-1:0] mem_q [SIZE];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter  int BITS = 32,
    parameter  int SIZE = 16,
    localparam int LW   = level_width(SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p_write_en,
    input  logic [BITS-1:0] p_write_data,
    input  logic            p_read_en,
    output logic [BITS-1:0] p_read_data,
    output logic            p_read_valid,
    output logic            p_full,
    output logic            p_empty,
    input  logic [LW-1:0]   p_af_thresh,
    input  logic [LW-1:0]   p_ae_thresh,
    output logic            p_almost_full,
    output logic            p_almost_empty,
    output logic [LW-1:0]   p_level,
    output logic            p_overflow,
    output logic            p_underflow,
    input  logic            p_clear_err
);

    localparam int            AW       = $clog2(SIZE);
    localparam logic [LW-1:0] FULL_LVL = LW'(SIZE);
    localparam logic [LW-1:0] ONE      = LW'(1);
    localparam logic [AW-1:0] PONE     = AW'(1);

    if ((SIZE < 2) || ((SIZE & (SIZE - 1)) != 0)) begin : g_size_chk
        $fatal(1, "sync_fifo_prog: SIZE must be a power of two >= 2");
    end

    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            full_q, empty_q, af_q, ae_q;
    err_t            err_q, err_d;
    logic            wr_acc, rd_acc;
    logic [BITS-1:0] mem_rdata;

    always_comb begin
        rd_acc = p_read_en && !empty_q;
        wr_acc = p_write_en && (!full_q || rd_acc);
        cnt_d  = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
        // A fresh error outranks a simultaneous clear.
        err_d = err_q;
        if (p_clear_err) err_d = '0;
        if (p_write_en && !wr_acc) err_d.overflow = 1'b1;
        if (p_read_en && !rd_acc) err_d.underflow = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (p_af_thresh == '0);
            ae_q    <= 1'b1;
            err_q   <= '0;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + PONE;
            if (rd_acc) rptr_q <= rptr_q + PONE;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_LVL);
            empty_q <= (cnt_d == '0);
            af_q    <= (cnt_d >= p_af_thresh);
            ae_q    <= (cnt_d <= p_ae_thresh);
            err_q   <= err_d;
        end
    end

    sync_fifo_mem #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc && rst_n),
        .waddr_i (wptr_q),
        .wdata_i (p_write_data),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign p_read_data  = empty_q ? '0 : mem_rdata;
    assign p_read_valid = !empty_q;
`else
    logic [BITS-1:0] rdata_q;
    logic            rvld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            rvld_q <= rd_acc;
            if (rd_acc) rdata_q <= mem_rdata;
        end
    end

    assign p_read_data  = rdata_q;
    assign p_read_valid = rvld_q;
`endif

    assign p_full         = full_q;
    assign p_empty        = empty_q;
    assign p_almost_full  = af_q;
    assign p_almost_empty = ae_q;
    assign p_level        = cnt_q;
    assign p_overflow     = err_q.overflow;
    assign p_underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed and seeded-random bench for sync_fifo_prog against a queue model.
module tb_sync_fifo_prog;

    localparam int BITS = 32;
    localparam int SIZE = 16;
    localparam int LW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            p_write_en = 1'b0;
    logic [BITS-1:0] p_write_data = '0;
    logic            p_read_en = 1'b0;
    logic [BITS-1:0] p_read_data;
    logic            p_read_valid;
    logic            p_full, p_empty;
    logic [LW-1:0]   p_af_thresh = 5'd12;
    logic [LW-1:0]   p_ae_thresh = 5'd2;
    logic            p_almost_full, p_almost_empty;
    logic [LW-1:0]   p_level;
    logic            p_overflow, p_underflow;
    logic            p_clear_err = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        ovf_m = 1'b0;
    logic        udf_m = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_prog #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p_write_en     (p_write_en),
        .p_write_data   (p_write_data),
        .p_read_en      (p_read_en),
        .p_read_data    (p_read_data),
        .p_read_valid   (p_read_valid),
        .p_full         (p_full),
        .p_empty        (p_empty),
        .p_af_thresh    (p_af_thresh),
        .p_ae_thresh    (p_ae_thresh),
        .p_almost_full  (p_almost_full),
        .p_almost_empty (p_almost_empty),
        .p_level        (p_level),
        .p_overflow     (p_overflow),
        .p_underflow    (p_underflow),
        .p_clear_err    (p_clear_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state();
        int n;
        n = q.size();
        chk("level", {27'd0, p_level}, 32'(n));
        chk("full", {31'd0, p_full}, {31'd0, n == SIZE});
        chk("empty", {31'd0, p_empty}, {31'd0, n == 0});
        chk("afull", {31'd0, p_almost_full}, {31'd0, n >= int'(p_af_thresh)});
        chk("aempty", {31'd0, p_almost_empty}, {31'd0, n <= int'(p_ae_thresh)});
        chk("ovf", {31'd0, p_overflow}, {31'd0, ovf_m});
        chk("udf", {31'd0, p_underflow}, {31'd0, udf_m});
`ifdef SYNC_FIFO_FWFT_EN
        chk("rvalid_fwft", {31'd0, p_read_valid}, {31'd0, n != 0});
`endif
    endtask

    task automatic cycle(input logic we, input logic [31:0] wd,
                         input logic re, input logic clr);
        logic        ra, wa;
        logic [31:0] exp;
        ra  = re && (q.size() > 0);
        wa  = we && ((q.size() < SIZE) || ra);
        exp = ra ? q[0] : 32'd0;
`ifdef SYNC_FIFO_FWFT_EN
        if (ra) chk("head", p_read_data, exp);
`endif
        p_write_en   = we;
        p_write_data = wd;
        p_read_en    = re;
        p_clear_err  = clr;
        step();
        p_write_en  = 1'b0;
        p_read_en   = 1'b0;
        p_clear_err = 1'b0;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(wd);
        if (clr) begin
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end
        if (we && !wa) ovf_m = 1'b1;
        if (re && !ra) udf_m = 1'b1;
`ifndef SYNC_FIFO_FWFT_EN
        chk("rvalid", {31'd0, p_read_valid}, {31'd0, ra});
        if (ra) chk("rdata", p_read_data, exp);
`endif
        chk_state();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        p_write_en   = 1'b1;
        p_write_data = 32'hBAD0BAD0;
        p_read_en    = 1'b1;
        step();
        rst_n      = 1'b1;
        p_write_en = 1'b0;
        p_read_en  = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        chk_state();
        chk("rst_rdata", p_read_data, 32'd0);
        chk("rst_rvalid", {31'd0, p_read_valid}, 32'd0);
    endtask

    initial begin
        void'($urandom(32'h00C0FFEE));
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 11) chk("af_at12", {31'd0, p_almost_full}, 32'd1);
        end
        chk("full16", {31'd0, p_full}, 32'd1);
        chk("lvl16", {27'd0, p_level}, 32'd16);
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("ovf17", {31'd0, p_overflow}, 32'd1);

        p_af_thresh = 5'd20;
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("af_hi_thr", {31'd0, p_almost_full}, 32'd0);
        p_af_thresh = 5'd12;
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("ovf_clr", {31'd0, p_overflow}, 32'd0);

        for (int i = 0; i < 16; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("empty_end", {31'd0, p_empty}, 32'd1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("udf_set", {31'd0, p_underflow}, 32'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("udf_clr", {31'd0, p_underflow}, 32'd0);

        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(100 + i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) cycle(1'b1, 32'(200 + k), 1'b1, 1'b0);
        chk("rw_lvl", {27'd0, p_level}, 32'd16);
        chk("rw_ovf", {31'd0, p_overflow}, 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);

        cycle(1'b1, 32'h77, 1'b1, 1'b0);
        chk("ewr_udf", {31'd0, p_underflow}, 32'd1);
        chk("ewr_lvl", {27'd0, p_level}, 32'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(50 + i), 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_lvl", {27'd0, p_level}, 32'd0);
        cycle(1'b1, 32'hA5, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter BITS, default 32, width of each entry.
REQ-002 Parameter SIZE, default 16, entry count; SHALL be a power of two and at least 2, else elaboration fatal.
REQ-003 Derived LW = $clog2(SIZE)+1, width of level and threshold ports.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 p_write_en  input  1  write request; p_write_data  input  BITS  write data.
REQ-007 p_read_en  input  1  read request; p_read_data  output  BITS  read data.
REQ-008 p_read_valid  output  1  p_read_data holds a popped or head entry.
REQ-009 p_full, p_empty  output  1 each  occupancy == SIZE, occupancy == 0.
REQ-010 p_af_thresh, p_ae_thresh  input  LW each  almost-full and almost-empty thresholds.
REQ-011 p_almost_full, p_almost_empty  output  1 each  level >= p_af_thresh, level <= p_ae_thresh.
REQ-012 p_level  output  LW  current occupancy, 0..SIZE.
REQ-013 p_overflow, p_underflow  output  1 each  sticky error flags; p_clear_err  input  1  clears both.

Function
REQ-014 A write SHALL be accepted when p_write_en=1 and p_full=0, or p_full=1 with a read accepted in the same cycle.
REQ-015 A read SHALL be accepted when p_read_en=1 and p_empty=0; a read with p_empty=1 SHALL be rejected even when a write is accepted in that cycle.
REQ-016 A rejected write SHALL leave storage unchanged and set p_overflow next cycle; a rejected read SHALL set p_underflow next cycle.
REQ-017 p_clear_err=1 SHALL clear both sticky flags next cycle; a new error in the same cycle SHALL take priority and set its flag.
REQ-018 Pointers SHALL be log2(SIZE) bits and wrap from SIZE-1 to 0; occupancy SHALL be an LW-bit counter.
REQ-019 Occupancy SHALL change by +1 on write only, -1 on read only, and 0 on both or neither.
REQ-020 p_level, p_full, p_empty, p_almost_full and p_almost_empty SHALL be registered and reflect occupancy one cycle after the accepting edge.
REQ-021 Threshold compares SHALL be unsigned on LW bits; thresholds above SIZE SHALL never assert almost_full.
REQ-022 Data SHALL leave in write order; no entry SHALL be lost or duplicated across wrap-around.

Reset
REQ-023 With rst_n=0 at a clock edge, pointers and occupancy SHALL reset to 0, p_empty=1, p_full=0, p_level=0, p_read_valid=0, and p_overflow=p_underflow=0.
REQ-024 p_almost_empty SHALL be 1 and p_almost_full SHALL be (p_af_thresh==0) after reset.
REQ-025 Reset mid-operation SHALL discard all stored entries; p_read_data SHALL be 0 after reset; storage contents need not be cleared.
REQ-026 Requests in the reset cycle SHALL be ignored and SHALL NOT set error flags.

Configuration
REQ-027 Macro SYNC_FIFO_FWFT_EN selects the read mode.
REQ-028 Without the macro (standard mode), an accepted read SHALL drive p_read_data with the entry one cycle later and pulse p_read_valid=1 for that cycle.
REQ-029 With the macro (first-word-fall-through mode), p_read_data SHALL show the head entry whenever p_empty=0 and p_read_valid SHALL equal !p_empty.
REQ-030 In first-word-fall-through mode, a write into an empty FIFO SHALL appear on p_read_data one cycle later; p_read_en pops the head shown.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold a level-width function and the error-flag struct typedef.
REQ-032 Storage SHALL be sub-module sync_fifo_mem: BITS x SIZE, one synchronous write port and one read port, with no reset on the array.
REQ-033 Control, counters, flags and read-mode logic SHALL reside in sync_fifo_prog.

Verification (BITS=32, SIZE=16, af=12, ae=2)
REQ-034 Write 16 words 0..15 back-to-back: p_full=1 after the 16th accepted edge, p_level=16, p_almost_full=1 from level 12, and a 17th write sets p_overflow.
REQ-035 Read all 16 words: the sequence out is 0..15, p_empty=1 at the end, and an extra read sets p_underflow; p_clear_err clears it.
REQ-036 Hold full, then read and write in the same cycle for 40 cycles: p_level stays 16, with no overflow and correct order through wrap-around.
REQ-037 Hold empty, then read and write in the same cycle: the write is accepted, the read is rejected, p_underflow=1, and p_level=1.
REQ-038 Write 5 words, then assert rst_n=0 for 1 cycle: p_empty=1, p_level=0, flags are 0, and a following write of 0xA5 reads back 0xA5.
REQ-039 Random read and write enables, seeded, for 2000 cycles in both macro settings: the scoreboard matches, with 0 errors.
